// File: rtl/display_scheduler_if.sv
// Bundle of the source digit buses, control levels and display outputs shared
// between the clock/alarm/stopwatch datapaths, the scheduler and the digit driver.
interface display_scheduler_if;
  logic        tick_1hz;
  logic        tick_blink;
  logic        btn_mode;
  logic        btn_ack;
  logic        set_active;
  logic        alarm_ring;
  logic        sw_running;
  logic [15:0] clk_op;
  logic [15:0] alarm_op;
  logic [15:0] sw_op;
  logic [15:0] op;
  logic [1:0]  op_mode;
  logic        blank;
  logic        ring_led;

  modport master (
    output tick_1hz, tick_blink, btn_mode, btn_ack, set_active, alarm_ring,
           sw_running, clk_op, alarm_op, sw_op,
    input  op, op_mode, blank, ring_led
  );

  modport slave (
    input  tick_1hz, tick_blink, btn_mode, btn_ack, set_active, alarm_ring,
           sw_running, clk_op, alarm_op, sw_op,
    output op, op_mode, blank, ring_led
  );
endinterface

// File: rtl/display_scheduler.sv
// Chooses which source owns the 16-bit display: clock, alarm setting, stopwatch
// or a preemptive blinking alarm-ring view, with idle return and set deferral.
module display_scheduler #(
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned RING_MAX_S = 60
) (
  input logic               clk,
  input logic               rst,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_CLOCK = 2'd0,
    S_ALARM = 2'd1,
    S_SW    = 2'd2,
    S_RING  = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);
  localparam logic [7:0] RING_LAST = 8'(RING_MAX_S - 1);

  state_t      state, state_next;
  state_t      saved_state, saved_next;
  logic [7:0]  idle_cnt, idle_next;
  logic [7:0]  ring_cnt, ring_cnt_next;
  logic        ring_pending, pending_next;
  logic        blank_q, blank_next;
  logic        ring_led_q;
  logic [15:0] op_q, op_sel;
  logic        btn_q, ack_q, ring_q, set_q;

  logic btn_rise, ack_rise, ring_rise, set_fall, idle_view;

  assign btn_rise  = bus.btn_mode   & ~btn_q;
  assign ack_rise  = bus.btn_ack    & ~ack_q;
  assign ring_rise = bus.alarm_ring & ~ring_q;
  assign set_fall  = ~bus.set_active & set_q;
  assign idle_view = (state == S_ALARM) || ((state == S_SW) && !bus.sw_running);

  function automatic state_t next_view(input state_t s);
    case (s)
      S_CLOCK: next_view = S_ALARM;
      S_ALARM: next_view = S_SW;
      default: next_view = S_CLOCK;
    endcase
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_next    = state;
    saved_next    = saved_state;
    idle_next     = idle_cnt;
    ring_cnt_next = ring_cnt;
    pending_next  = ring_pending;
    blank_next    = blank_q;

    if (state == S_RING) begin
      idle_next = 8'd0;
      if (ack_rise || !bus.alarm_ring ||
          (bus.tick_1hz && (ring_cnt == RING_LAST))) begin
        state_next    = saved_state;
        blank_next    = 1'b0;
        ring_cnt_next = 8'd0;
      end else begin
        if (bus.tick_1hz)   ring_cnt_next = ring_cnt + 8'd1;
        if (bus.tick_blink) blank_next    = ~blank_q;
      end
    end else begin
      if (ring_rise && bus.set_active) pending_next = 1'b1;

      // Ring preemption outranks the mode button; a deferred ring fires when
      // editing ends, but only if the alarm is still asserted.
      if ((ring_rise && !bus.set_active) ||
          (set_fall && ring_pending && bus.alarm_ring)) begin
        state_next    = S_RING;
        saved_next    = state;
        ring_cnt_next = 8'd0;
        blank_next    = 1'b0;
        pending_next  = 1'b0;
      end else if (set_fall && ring_pending) begin
        pending_next = 1'b0;
      end else if (!bus.set_active && btn_rise) begin
        state_next = next_view(state);
      end else if (!bus.set_active && idle_view && bus.tick_1hz &&
                   (idle_cnt == IDLE_LAST)) begin
        state_next = S_CLOCK;
      end

      if ((state_next != state) || bus.sw_running) begin
        idle_next = 8'd0;
      end else if (bus.set_active) begin
        idle_next = idle_cnt;
      end else if (btn_rise) begin
        idle_next = 8'd0;
      end else if (idle_view && bus.tick_1hz) begin
        idle_next = idle_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    op_sel = bus.clk_op;
    case (state)
      S_CLOCK: op_sel = bus.clk_op;
      S_ALARM: op_sel = bus.alarm_op;
      S_SW:    op_sel = bus.sw_op;
      S_RING:  op_sel = bus.alarm_op;
      default: op_sel = bus.clk_op;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLOCK;
      saved_state  <= S_CLOCK;
      idle_cnt     <= 8'd0;
      ring_cnt     <= 8'd0;
      ring_pending <= 1'b0;
      blank_q      <= 1'b0;
      ring_led_q   <= 1'b0;
      op_q         <= 16'd0;
      btn_q        <= 1'b0;
      ack_q        <= 1'b0;
      ring_q       <= 1'b0;
      set_q        <= 1'b0;
    end else begin
      state        <= state_next;
      saved_state  <= saved_next;
      idle_cnt     <= idle_next;
      ring_cnt     <= ring_cnt_next;
      ring_pending <= pending_next;
      blank_q      <= blank_next;
      ring_led_q   <= (state_next == S_RING);
      op_q         <= op_sel;
      btn_q        <= bus.btn_mode;
      ack_q        <= bus.btn_ack;
      ring_q       <= bus.alarm_ring;
      set_q        <= bus.set_active;
    end
  end

  assign bus.op       = op_q;
  assign bus.op_mode  = state;
  assign bus.blank    = blank_q;
  assign bus.ring_led = ring_led_q;

endmodule
